// File: rtl/uart_rx_path.sv
//------------------------------------------------------------------------------
// Module   : uart_rx_path
// Purpose  : UART receive path: 8N1 deserialiser feeding a show-ahead RX FIFO.
//            Define UART_RX_PARITY_EN to receive 8E1 frames (even parity check).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_rx_path #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_AW      = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_rxd,
  input  logic       i_rx_valid,
  output logic [7:0] o_rx,
  output logic       o_irq,
  output logic       o_rx_busy,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_rx_full,
  output logic       o_rx_empty
);

  localparam int                 DEPTH     = 1 << FIFO_AW;
  localparam int                 BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0]      HALF_LOAD = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0]      FULL_LOAD = BW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0]   DEPTH_C   = (FIFO_AW + 1)'(DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_ERR    = 3'd5;

  logic               rxd_meta_q, rxd_sync_q, rxd_hist_q;
  logic [2:0]         state_q, state_d;
  logic [BW-1:0]      baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               push;
  logic               stop_ok;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               irq_q, irq_d, ovr_q, ovr_d;
  logic               pop, accept, fifo_full, fifo_empty;
  logic [7:0]         mem_q [DEPTH];
`ifdef UART_RX_PARITY_EN
  logic               par_err_q, par_err_d;
  assign stop_ok = rxd_sync_q && !par_err_q;
`else
  assign stop_ok = rxd_sync_q;
`endif

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    push    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d = par_err_q;
`endif
    if (state_q != S_IDLE && baud_q != '0) begin
      baud_d = baud_q - 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          // Only a fresh falling edge starts a frame, so a held break is ignored.
          if (rxd_hist_q && !rxd_sync_q) begin
            state_d = S_START;
            baud_d  = HALF_LOAD;
          end
        end
        S_START: begin
          baud_d = FULL_LOAD;
          bit_d  = 3'd0;
          state_d = rxd_sync_q ? S_IDLE : S_DATA;
        end
        S_DATA: begin
          shift_d = {rxd_sync_q, shift_q[7:1]};
          baud_d  = FULL_LOAD;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          par_err_d = rxd_sync_q ^ (^shift_q);
          baud_d    = FULL_LOAD;
          state_d   = S_STOP;
        end
`endif
        S_STOP: begin
          push    = stop_ok;
          state_d = stop_ok ? S_IDLE : S_ERR;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // A push into a full FIFO is still accepted when a pop frees a slot in the same cycle.
  always_comb begin
    fifo_full  = (count_q == DEPTH_C);
    fifo_empty = (count_q == '0);
    pop        = i_rx_valid && !fifo_empty;
    accept     = push && (!fifo_full || pop);
    wr_ptr_d   = wr_ptr_q + FIFO_AW'(accept);
    rd_ptr_d   = rd_ptr_q + FIFO_AW'(pop);
    count_d    = count_q + (FIFO_AW + 1)'(accept) - (FIFO_AW + 1)'(pop);
    irq_d      = accept;
    ovr_d      = push && !accept;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_hist_q <= 1'b1;
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      irq_q      <= 1'b0;
      ovr_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q  <= 1'b0;
`endif
    end else begin
      rxd_meta_q <= i_rxd;
      rxd_sync_q <= rxd_meta_q;
      rxd_hist_q <= rxd_sync_q;
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      irq_q      <= irq_d;
      ovr_q      <= ovr_d;
`ifdef UART_RX_PARITY_EN
      par_err_q  <= par_err_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  assign o_rx        = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];
  assign o_irq       = irq_q;
  assign o_rx_busy   = (state_q != S_IDLE);
  assign o_frame_err = (state_q == S_ERR);
  assign o_overrun   = ovr_q;
  assign o_rx_full   = fifo_full;
  assign o_rx_empty  = fifo_empty;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_path.sv
//------------------------------------------------------------------------------
// Module   : tb_uart_rx_path
// Purpose  : Directed self-checking bench for uart_rx_path (CLKS_PER_BIT=8, FIFO_AW=3).
//            Honours UART_RX_PARITY_EN for 8E1 frames.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_rx_path;

  localparam int CPB = 8;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // Loop index of the cycle whose following edge samples the stop bit.
  localparam int STOP_K = NBITS * CPB - 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_rxd = 1'b1;
  logic       i_rx_valid = 1'b0;
  logic [7:0] o_rx;
  logic       o_irq, o_rx_busy, o_frame_err, o_overrun, o_rx_full, o_rx_empty;

  int n_checks = 0;
  int n_fail = 0;
  int irq_cnt = 0, ferr_cnt = 0, ferr_nobusy = 0, ovr_cnt = 0, busy_cnt = 0;
  int irq0, ferr0, ovr0, busy0;

  uart_rx_path #(.CLKS_PER_BIT(CPB), .FIFO_AW(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rxd       (i_rxd),
    .i_rx_valid  (i_rx_valid),
    .o_rx        (o_rx),
    .o_irq       (o_irq),
    .o_rx_busy   (o_rx_busy),
    .o_frame_err (o_frame_err),
    .o_overrun   (o_overrun),
    .o_rx_full   (o_rx_full),
    .o_rx_empty  (o_rx_empty)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_irq) irq_cnt++;
    if (o_overrun) ovr_cnt++;
    if (o_rx_busy) busy_cnt++;
    if (o_frame_err) begin
      ferr_cnt++;
      if (!o_rx_busy) ferr_nobusy++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic snap();
    irq0 = irq_cnt; ferr0 = ferr_cnt; ovr0 = ovr_cnt; busy0 = busy_cnt;
  endtask

  // Drives one frame; line is left at the stop-bit level. pop_k < 0 means no pop.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                            input logic par_flip, input int pop_k);
    logic [10:0] bits;
`ifdef UART_RX_PARITY_EN
    bits = {stop_bit, (^data) ^ par_flip, data, 1'b0};
`else
    bits = {par_flip, stop_bit, data, 1'b0};
`endif
    for (int k = 0; k < NBITS * CPB; k++) begin
      i_rxd      = bits[k / CPB];
      i_rx_valid = (k == pop_k);
      @(posedge clk);
      #1;
    end
    i_rx_valid = 1'b0;
  endtask

  task automatic send_ok(input logic [7:0] data);
    send_frame(data, 1'b1, 1'b0, -1);
    wait_cycles(4);
  endtask

  task automatic pop_one();
    i_rx_valid = 1'b1;
    @(posedge clk);
    #1;
    i_rx_valid = 1'b0;
    wait_cycles(1);
  endtask

  initial begin
    // 1. reset and idle line
    wait_cycles(3);
    rst_n = 1'b1;
    snap();
    wait_cycles(100);
    check("rst_empty", o_rx_empty, 1);
    check("rst_full", o_rx_full, 0);
    check("rst_rx", o_rx, 8'h00);
    check("rst_busy", o_rx_busy, 0);
    check("rst_pulses", irq_cnt + ferr_cnt + ovr_cnt + busy_cnt, 0);

    // 2. single good byte
    snap();
    send_ok(8'hA5);
    check("a5_busy_len", (busy_cnt - busy0 >= 74) && (busy_cnt - busy0 <= 78 + (NBITS - 10) * CPB), 1);
    check("a5_irq", irq_cnt - irq0, 1);
    check("a5_ferr", ferr_cnt - ferr0, 0);
    check("a5_rx", o_rx, 8'hA5);
    check("a5_empty", o_rx_empty, 0);
    pop_one();
    check("a5_pop_empty", o_rx_empty, 1);
    check("a5_pop_rx", o_rx, 8'h00);
    pop_one();
    check("pop_when_empty", o_rx_empty, 1);

    // 3. short glitch
    snap();
    i_rxd = 1'b0;
    wait_cycles(3);
    i_rxd = 1'b1;
    wait_cycles(20);
    check("glitch_irq", irq_cnt - irq0, 0);
    check("glitch_ferr", ferr_cnt - ferr0, 0);
    check("glitch_busy", o_rx_busy, 0);
    check("glitch_empty", o_rx_empty, 1);

    // 4. bad stop bit, then a held break, then recovery
    snap();
    send_frame(8'h3C, 1'b0, 1'b0, -1);
    wait_cycles(4);
    check("ferr_pulse", ferr_cnt - ferr0, 1);
    check("ferr_with_busy", ferr_nobusy, 0);
    check("ferr_irq", irq_cnt - irq0, 0);
    check("ferr_empty", o_rx_empty, 1);
    snap();
    wait_cycles(200);
    check("break_busy", busy_cnt - busy0, 0);
    check("break_ferr", ferr_cnt - ferr0, 0);
    i_rxd = 1'b1;
    wait_cycles(20);
    snap();
    send_ok(8'h11);
    check("recover_irq", irq_cnt - irq0, 1);
    check("recover_rx", o_rx, 8'h11);
    pop_one();

    // 5. fill, overrun, push+pop while full
    snap();
    for (int i = 0; i < 8; i++) send_ok(8'(i));
    check("fill_irq", irq_cnt - irq0, 8);
    check("fill_full", o_rx_full, 1);
    check("fill_head", o_rx, 8'h00);
    snap();
    send_ok(8'h08);
    check("ovr_pulse", ovr_cnt - ovr0, 1);
    check("ovr_irq", irq_cnt - irq0, 0);
    check("ovr_head", o_rx, 8'h00);
    snap();
    send_frame(8'h08, 1'b1, 1'b0, STOP_K);
    wait_cycles(4);
    check("pp_ovr", ovr_cnt - ovr0, 0);
    check("pp_irq", irq_cnt - irq0, 1);
    check("pp_full", o_rx_full, 1);
    for (int i = 1; i <= 8; i++) begin
      check("drain_head", o_rx, 32'(i));
      pop_one();
    end
    check("drain_empty", o_rx_empty, 1);

    // Reset mid-frame empties the FIFO and emits nothing
    send_ok(8'h5A);
    check("pre_rst_empty", o_rx_empty, 0);
    snap();
    i_rxd = 1'b0;
    wait_cycles(30);
    rst_n = 1'b0;
    #2;
    check("midrst_busy", o_rx_busy, 0);
    check("midrst_empty", o_rx_empty, 1);
    check("midrst_rx", o_rx, 8'h00);
    wait_cycles(2);
    i_rxd = 1'b1;
    rst_n = 1'b1;
    wait_cycles(20);
    check("midrst_pulses", (irq_cnt - irq0) + (ferr_cnt - ferr0) + (ovr_cnt - ovr0), 0);

`ifdef UART_RX_PARITY_EN
    // 6. parity checking
    snap();
    send_frame(8'h01, 1'b1, 1'b1, -1);
    i_rxd = 1'b1;
    wait_cycles(4);
    check("par_bad_ferr", ferr_cnt - ferr0, 1);
    check("par_bad_empty", o_rx_empty, 1);
    snap();
    send_ok(8'h01);
    check("par_ok_ferr", ferr_cnt - ferr0, 0);
    check("par_ok_rx", o_rx, 8'h01);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
